// File: rtl/wb_master_posted_if_pkg.sv
// Shared definitions for the Wishbone posted-write master: FSM states,
// stall/write constants and the failure-event rule.
package wb_master_posted_if_pkg;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_POST           = 2'b10,
    WB_WAIT_FOR_STALL = 2'b11
  } wb_state_t;

  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  // A slave error always wins; an expired wait only fails if the slave did not ack in that cycle.
  function automatic logic fail_event(input logic err, input logic expired, input logic ack);
    return err | (expired & ~ack);
  endfunction

endpackage

// File: rtl/wb_master_posted_if_timeout_ctr.sv
// Bounded-wait counter: counts strobe cycles without a response and
// saturates at TIMEOUT. TIMEOUT = 0 disables expiry entirely.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + TO_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/wb_master_posted_if.sv
// Wishbone B3 classic single-cycle master for the CPU pipeline, with bus
// error handling, a bounded-wait timeout and optional posted writes.
module wb_master_posted_if
  import wb_master_posted_if_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int SW        = DW / 8,
  parameter int STALL_W   = 6,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8,
  parameter int POSTED_WR = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [DW-1:0]      cpu_data_i,
  input  logic               cpu_we_i,
  input  logic [SW-1:0]      cpu_sel_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               cpu_err_o,
  output logic               wr_err_o,
  output logic               stallreq,
  input  logic [DW-1:0]      wb_data_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  output logic [AW-1:0]      wb_addr_o,
  output logic [DW-1:0]      wb_data_o,
  output logic               wb_we_o,
  output logic [SW-1:0]      wb_sel_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o
);

  wb_state_t     state;
  logic [DW-1:0] rd_buf;
  logic          err_buf;

  logic expired;
  logic fail;
  logic ack_ok;
  logic term;
  logic stalled;
  logic launch;
  logic posted_req;
  logic bus_release;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch),
    .run     (wb_stb_o & ~wb_ack_i & ~wb_err_i),
    .expired (expired)
  );

  always_comb begin
    fail        = fail_event(wb_err_i, expired, wb_ack_i);
    ack_ok      = wb_ack_i & ~fail;
    term        = ack_ok | fail;
    stalled     = |stall_i;
    posted_req  = cpu_we_i & (POSTED_WR != 0);
    launch      = (state == WB_IDLE) & cpu_ce_i & ~flush_i;
    bus_release = ((state == WB_BUSY) & (term | flush_i)) |
                  ((state == WB_POST) & term);
  end

  // CPU-facing outputs are gated by reset so an in-flight transfer cannot report an error while being reset.
  always_comb begin
    cpu_data_o = '0;
    cpu_err_o  = 1'b0;
    wr_err_o   = 1'b0;
    stallreq   = NO_STOP;
    if (!rst) begin
      unique case (state)
        WB_IDLE: begin
          stallreq = (launch & ~posted_req) ? STOP : NO_STOP;
        end
        WB_BUSY: begin
          if (term) begin
            cpu_err_o = fail;
            if (ack_ok && !wb_we_o) begin
              cpu_data_o = wb_data_i;
            end
          end else if (!flush_i) begin
            stallreq = STOP;
          end
        end
        WB_POST: begin
          wr_err_o = fail;
          stallreq = cpu_ce_i ? STOP : NO_STOP;
        end
        WB_WAIT_FOR_STALL: begin
          cpu_data_o = rd_buf;
          cpu_err_o  = err_buf;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WB_IDLE;
      rd_buf    <= '0;
      err_buf   <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_we_o   <= WRITE_DISABLE;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      if (launch) begin
        wb_addr_o <= cpu_addr_i;
        wb_data_o <= cpu_data_i;
        wb_we_o   <= cpu_we_i;
        wb_sel_o  <= cpu_sel_i;
        wb_stb_o  <= 1'b1;
        wb_cyc_o  <= 1'b1;
      end else if (bus_release) begin
        wb_addr_o <= '0;
        wb_data_o <= '0;
        wb_we_o   <= WRITE_DISABLE;
        wb_sel_o  <= '0;
        wb_stb_o  <= 1'b0;
        wb_cyc_o  <= 1'b0;
      end

      unique case (state)
        WB_IDLE: begin
          if (launch) begin
            state <= posted_req ? WB_POST : WB_BUSY;
          end
        end
        WB_BUSY: begin
          if (term) begin
            // A stalled pipeline cannot take the result yet, so park it until the stall clears.
            if (stalled) begin
              rd_buf  <= (ack_ok && !wb_we_o) ? wb_data_i : '0;
              err_buf <= fail;
              state   <= WB_WAIT_FOR_STALL;
            end else begin
              state <= WB_IDLE;
            end
          end else if (flush_i) begin
            state <= WB_IDLE;
          end
        end
        WB_POST: begin
          if (term) begin
            state <= WB_IDLE;
          end
        end
        WB_WAIT_FOR_STALL: begin
          if (!stalled) begin
            err_buf <= 1'b0;
            state   <= WB_IDLE;
          end
        end
      endcase
    end
  end

endmodule
